// File: rtl/wb_mem_responder_if.sv
// rtl/wb_mem_responder_if.sv - pipelined Wishbone B4 bus bundle between a master and the memory responder
interface wb_mem_responder_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        wb_cyc_i;
  logic        wb_stall_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );
endinterface

// File: rtl/wb_mem_responder.sv
// rtl/wb_mem_responder.sv - word-addressed on-chip memory behind a pipelined Wishbone slave
// Fixed-latency responses, byte-enable writes, stall at the outstanding-request limit.
module wb_mem_responder #(
  parameter int DEPTH_LOG2      = 10,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  wb_mem_responder_if.slave wb
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]           mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic [LATENCY-1:0]    pipe_vld;
  logic [31:0]           pipe_dat [LATENCY];
  logic [CW-1:0]         cnt;
  logic                  unused_adr;

  // Upper address bits are dropped so out-of-range addresses alias onto the array.
  assign idx        = wb.wb_adr_i[DEPTH_LOG2+1:2];
  assign unused_adr = ^{wb.wb_adr_i[31:DEPTH_LOG2+2], wb.wb_adr_i[1:0]};
  assign accept     = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_stall_o;

  always_ff @(posedge clk_i) begin
    if (accept && wb.wb_we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (wb.wb_sel_i[k]) mem[idx][8*k +: 8] <= wb.wb_dat_i[8*k +: 8];
      end
    end
  end

  // Data lanes carry no reset; the output mux zeroes them whenever ack is low.
  always_ff @(posedge clk_i) begin
    pipe_dat[0] <= wb.wb_we_i ? 32'h0 : mem[idx];
    for (int i = 1; i < LATENCY; i++) pipe_dat[i] <= pipe_dat[i-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !wb.wb_cyc_i) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !wb.wb_cyc_i) begin
      cnt <= '0;
    end else begin
      case ({accept, wb.wb_ack_o})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Stall ignores a same-cycle retiring ack, trading one cycle for a registered-only path.
  assign wb.wb_stall_o = (cnt == CW'(MAX_OUTSTANDING));
  assign wb.wb_ack_o   = pipe_vld[LATENCY-1];
  assign wb.wb_dat_o   = pipe_vld[LATENCY-1] ? pipe_dat[LATENCY-1] : 32'h0;
endmodule

// File: tb/tb_wb_mem_responder.sv
// tb/tb_wb_mem_responder.sv - directed bench for wb_mem_responder against a queue-based response model
module tb_wb_mem_responder;
  localparam int ND = 4;
  localparam int LAT [ND] = '{2, 4, 4, 1};
  localparam int MO  [ND] = '{4, 2, 4, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc_d [ND];
  logic        stb_d [ND];
  logic        we_d  [ND];
  logic [3:0]  sel_d [ND];
  logic [31:0] adr_d [ND];
  logic [31:0] wd_d  [ND];
  logic        ack_s   [ND];
  logic        stall_s [ND];
  logic [31:0] dat_s   [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    wb_mem_responder_if bus ();
    assign bus.wb_cyc_i = cyc_d[g];
    assign bus.wb_stb_i = stb_d[g];
    assign bus.wb_we_i  = we_d[g];
    assign bus.wb_sel_i = sel_d[g];
    assign bus.wb_adr_i = adr_d[g];
    assign bus.wb_dat_i = wd_d[g];
    assign ack_s[g]     = bus.wb_ack_o;
    assign stall_s[g]   = bus.wb_stall_o;
    assign dat_s[g]     = bus.wb_dat_o;
    wb_mem_responder #(
      .DEPTH_LOG2(10), .LATENCY(LAT[g]), .MAX_OUTSTANDING(MO[g])
    ) dut (
      .clk_i(clk), .rst_i(rst), .wb(bus)
    );
  end

  int errors = 0;
  int n_checks = 0;
  int cyc_no = 0;
  bit armed = 0;

  // Model: pending responses per DUT, each with the cycle its ack must appear in.
  int          qn   [ND];
  int          qdue [ND][8];
  logic [31:0] qdat [ND][8];
  bit          qwe  [ND][8];
  logic [31:0] mmem [ND][1024];
  int          ack_cnt [ND];
  int          ack_log [ND][64];
  int          rd_cnt  [ND];
  logic [31:0] rd_log  [ND][64];
  bit          stall_seen [ND];

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc_no, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic        eack;
    logic        estall;
    logic        acc;
    logic [31:0] edat;
    int          idx;
    cyc_no++;
    for (int d = 0; d < ND; d++) begin
      eack   = (qn[d] > 0) && (qdue[d][0] == cyc_no);
      edat   = eack ? qdat[d][0] : 32'h0;
      estall = (qn[d] == MO[d]);
      if (armed) begin
        chk(d, "ack", {31'h0, ack_s[d]}, {31'h0, eack});
        chk(d, "dat", dat_s[d], edat);
        chk(d, "stall", {31'h0, stall_s[d]}, {31'h0, estall});
        if (ack_s[d] === 1'b1) begin
          if (ack_cnt[d] < 64) ack_log[d][ack_cnt[d]] = cyc_no;
          ack_cnt[d]++;
          if (eack && !qwe[d][0] && rd_cnt[d] < 64) begin
            rd_log[d][rd_cnt[d]] = dat_s[d];
            rd_cnt[d]++;
          end
        end
        if (stall_s[d] === 1'b1) stall_seen[d] = 1'b1;
      end
      if (eack) begin
        for (int i = 0; i < 7; i++) begin
          qdue[d][i] = qdue[d][i+1];
          qdat[d][i] = qdat[d][i+1];
          qwe[d][i]  = qwe[d][i+1];
        end
        qn[d]--;
      end
      acc = !rst && cyc_d[d] && stb_d[d] && !estall;
      if (acc && qn[d] < 8) begin
        idx = int'(adr_d[d][11:2]);
        qdue[d][qn[d]] = cyc_no + LAT[d];
        qdat[d][qn[d]] = we_d[d] ? 32'h0 : mmem[d][idx];
        qwe[d][qn[d]]  = we_d[d];
        qn[d]++;
        if (we_d[d]) begin
          for (int k = 0; k < 4; k++)
            if (sel_d[d][k]) mmem[d][idx][8*k +: 8] = wd_d[d][8*k +: 8];
        end
      end
      if (rst || !cyc_d[d]) qn[d] = 0;
    end
    if (rst) armed = 1'b1;
  end

  task automatic issue(input int d, input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [3:0] sel, output int acc);
    logic st;
    bit   done;
    done = 0;
    acc  = -1;
    we_d[d] = we; adr_d[d] = adr; wd_d[d] = wd; sel_d[d] = sel; stb_d[d] = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      st = stall_s[d];
      @(posedge clk);
      #1;
      if (!st) begin
        done = 1;
        acc  = cyc_no + 1;
      end
    end
    stb_d[d] = 1'b0;
    if (!done) begin
      n_checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d adr %h: got no acceptance expected one within 50 cycles", d, adr);
    end
  endtask

  task automatic wait_acks(input int d, input int n);
    for (int t = 0; t < 60 && ack_cnt[d] < n; t++) @(posedge clk);
    #1;
    chk(d, "ack_count", ack_cnt[d], n);
  endtask

  int a0, a1, ab, rb;
  int accs [8];

  initial begin
    for (int d = 0; d < ND; d++) begin
      cyc_d[d] = 0; stb_d[d] = 0; we_d[d] = 0; sel_d[d] = 0; adr_d[d] = 0; wd_d[d] = 0;
      qn[d] = 0; ack_cnt[d] = 0; rd_cnt[d] = 0; stall_seen[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk(0, "rst_ack", {31'h0, ack_s[0]}, 32'h0);
    chk(0, "rst_dat", dat_s[0], 32'h0);
    chk(0, "rst_stall", {31'h0, stall_s[0]}, 32'h0);
    chk(0, "rst_cnt", 32'(g_dut[0].dut.cnt), 32'h0);

    // Single write then read, latency 2
    cyc_d[0] = 1'b1;
    ab = ack_cnt[0]; rb = rd_cnt[0];
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF, a1);
    wait_acks(0, ab + 2);
    chk(0, "wr_lat", ack_log[0][ab] - a0, 32'd1);
    chk(0, "rd_lat", ack_log[0][ab+1] - a1, 32'd1);
    chk(0, "rd_data", rd_log[0][rb], 32'hDEADBEEF);

    // Byte enables
    ab = ack_cnt[0]; rb = rd_cnt[0];
    issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF, a0);
    issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, a0);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, a0);
    wait_acks(0, ab + 3);
    chk(0, "byte_en", rd_log[0][rb], 32'h11BB33DD);

    // Back-to-back reads of preloaded words
    ab = ack_cnt[0];
    for (int k = 0; k < 8; k++) issue(0, 1'b1, 32'(k * 4), 32'(k), 4'hF, a0);
    wait_acks(0, ab + 8);
    stall_seen[0] = 1'b0;
    ab = ack_cnt[0]; rb = rd_cnt[0];
    for (int k = 0; k < 8; k++) issue(0, 1'b0, 32'(k * 4), 32'h0, 4'hF, accs[k]);
    wait_acks(0, ab + 8);
    for (int k = 0; k < 8; k++) begin
      chk(0, "b2b_data", rd_log[0][rb+k], 32'(k));
      chk(0, "b2b_accept", accs[k] - accs[0], 32'(k));
      chk(0, "b2b_ack", ack_log[0][ab+k] - accs[0], 32'(k + 1));
    end
    chk(0, "b2b_no_stall", {31'h0, stall_seen[0]}, 32'h0);

    // Stall at the limit: latency 4, two outstanding
    cyc_d[1] = 1'b1;
    ab = ack_cnt[1];
    for (int k = 0; k < 6; k++) issue(1, 1'b1, 32'(k * 4), 32'h100 + 32'(k), 4'hF, a0);
    wait_acks(1, ab + 6);
    ab = ack_cnt[1]; rb = rd_cnt[1];
    for (int k = 0; k < 6; k++) issue(1, 1'b0, 32'(k * 4), 32'h0, 4'hF, accs[k]);
    wait_acks(1, ab + 6);
    chk(1, "stall_acc1", accs[1] - accs[0], 32'd1);
    chk(1, "stall_acc2", accs[2] - accs[0], 32'd5);
    chk(1, "stall_first_ack", ack_log[1][ab] - accs[0], 32'd3);
    for (int k = 0; k < 6; k++) chk(1, "stall_data", rd_log[1][rb+k], 32'h100 + 32'(k));

    // Abort with three reads in flight
    cyc_d[2] = 1'b1;
    ab = ack_cnt[2];
    for (int k = 0; k < 3; k++) issue(2, 1'b1, 32'(k * 4), 32'h200 + 32'(k), 4'hF, a0);
    wait_acks(2, ab + 3);
    ab = ack_cnt[2];
    for (int k = 0; k < 3; k++) issue(2, 1'b0, 32'(k * 4), 32'h0, 4'hF, a0);
    cyc_d[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk(2, "abort_no_ack", ack_cnt[2], ab);
    chk(2, "abort_cnt", 32'(g_dut[2].dut.cnt), 32'h0);
    cyc_d[2] = 1'b1;
    rb = rd_cnt[2];
    issue(2, 1'b0, 32'h4, 32'h0, 4'hF, a0);
    wait_acks(2, ab + 1);
    chk(2, "abort_new_read", rd_log[2][rb], 32'h201);

    // Reset with two reads in flight
    ab = ack_cnt[2];
    issue(2, 1'b0, 32'h0, 32'h0, 4'hF, a0);
    issue(2, 1'b0, 32'h8, 32'h0, 4'hF, a0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk(2, "rst_mid_ack", {31'h0, ack_s[2]}, 32'h0);
    chk(2, "rst_mid_dat", dat_s[2], 32'h0);
    chk(2, "rst_mid_stall", {31'h0, stall_s[2]}, 32'h0);
    chk(2, "rst_mid_cnt", 32'(g_dut[2].dut.cnt), 32'h0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk(2, "rst_no_ack", ack_cnt[2], ab);

    // Latency 1, single outstanding
    cyc_d[3] = 1'b1;
    ab = ack_cnt[3]; rb = rd_cnt[3];
    issue(3, 1'b1, 32'h14, 32'h33, 4'hF, a0);
    issue(3, 1'b0, 32'h14, 32'h0, 4'hF, a1);
    wait_acks(3, ab + 2);
    chk(3, "lat1_ack", ack_log[3][ab] - a0, 32'd0);
    chk(3, "lat1_gap", a1 - a0, 32'd2);
    chk(3, "lat1_data", rd_log[3][rb], 32'h33);

    // Address wrap
    ab = ack_cnt[0]; rb = rd_cnt[0];
    issue(0, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, a0);
    issue(0, 1'b0, 32'h0, 32'h0, 4'hF, a0);
    wait_acks(0, ab + 2);
    chk(0, "wrap", rd_log[0][rb], 32'h5A5A5A5A);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end
endmodule
